regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, the register count (power of two, at least 4); AW = log2(NREG).
REQ-003 The block SHALL have parameter NRD, default 2, the number of read ports (1 to 4).
REQ-004 The block SHALL have parameter BYPASS, default 1; 1 enables same-cycle write-to-read forwarding.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port ra, input, NRD*AW bits: packed read addresses, port i at [i*AW +: AW].
REQ-008 The block SHALL have port rd, output, NRD*XLEN bits: packed read data, port i at [i*XLEN +: XLEN].
REQ-009 The block SHALL have port rbusy, output, NRD bits: per-read-port busy flag of the addressed register.
REQ-010 The block SHALL have ports we0 (1 bit), wa0 (AW bits) and wd0 (XLEN bits), all inputs: write port 0 (ALU writeback).
REQ-011 The block SHALL have ports we1 (1 bit), wa1 (AW bits) and wd1 (XLEN bits), all inputs: write port 1 (load writeback).
REQ-012 The block SHALL have ports iss_v (1 bit) and iss_a (AW bits), both inputs: issue request marking register iss_a as pending.
REQ-013 The block SHALL have port busy_vec, output, NREG bits: the current scoreboard state, bit n set when register n is pending.

Function
REQ-014 Register 0 SHALL read as 0, never be written, and never be marked busy, with no exceptions.
REQ-015 Read path SHALL be combinational; rd port i = mem[ra_i], except as required by REQ-016.
REQ-016 With BYPASS=1, if a write to ra_i != 0 is enabled in the same cycle, rd port i SHALL be the write data of the winning port (REQ-018); with BYPASS=0 it SHALL return the stored value.
REQ-017 Writes SHALL take effect at the rising edge when weN=1 and waN != 0.
REQ-018 On simultaneous we0 and we1 to the same address, port 1 SHALL win; to different addresses, both writes SHALL complete in the same cycle.
REQ-019 busy[n] SHALL set at the edge when iss_v=1 and iss_a=n (n != 0).
REQ-020 busy[n] SHALL clear at the edge when either write port writes n and no issue to n occurs in that cycle.
REQ-021 On same-cycle issue and writeback to the same n, set SHALL win: busy[n]=1 after the edge and the data SHALL be written.
REQ-022 Issue to an already-busy register SHALL keep it busy, with no error and no count (single outstanding writer per register).
REQ-023 rbusy[i] SHALL be busy[ra_i] && !(write to ra_i this cycle), so that a forwarded value reports not-busy; with BYPASS=0 it SHALL be busy[ra_i].
REQ-024 Writeback to a non-busy register SHALL be permitted and SHALL update the data; busy SHALL stay 0.
REQ-025 busy_vec SHALL be registered state, with no combinational path from inputs.

Reset
REQ-026 While rst=1 at an edge, all registers SHALL be set to 0 and all busy bits to 0 in that single cycle, ignoring we0, we1 and iss_v.
REQ-027 Reset asserted mid-operation SHALL discard pending busy bits; a writeback in the first cycle after reset SHALL write data and leave busy 0.
REQ-028 After reset, rd SHALL be 0 for every address and rbusy and busy_vec SHALL be all 0.

Verification
REQ-029 Scenario: rst for 1 cycle, then read all addresses on every port -> rd=0, rbusy=0, busy_vec=0.
REQ-030 Scenario: we0 wa0=5 wd0=0xDEADBEEF, ra0=5 in the same cycle -> rd0=0xDEADBEEF with BYPASS=1, 0 with BYPASS=0; the next cycle -> 0xDEADBEEF in both modes.
REQ-031 Scenario: we0 and we1 both to address 7, wd0=0x11, wd1=0x22 -> the next read of 7 returns 0x22.
REQ-032 Scenario: iss_v iss_a=3, then 2 idle cycles, then we1 wa1=3 wd1=0x55 -> busy_vec[3]=1 for 3 cycles, rbusy=0 during the writeback cycle with BYPASS=1, busy_vec[3]=0 after it.
REQ-033 Scenario: iss_v iss_a=9 and we0 wa0=9 wd0=0x1 in the same cycle -> after the edge busy_vec[9]=1 and mem[9]=0x1.
REQ-034 Scenario: writes and issues to address 0 -> rd=0, busy_vec[0]=0; rst asserted with busy_vec=0x0000_0208 -> busy_vec=0 the next cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Multi-read, dual-write register file with a per-register
//               pending-writer scoreboard and optional write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NRD*$clog2(NREG)-1:0]   ra,
    output logic [NRD*XLEN-1:0]           rd,
    output logic [NRD-1:0]                rbusy,
    input  logic                          we0,
    input  logic [$clog2(NREG)-1:0]       wa0,
    input  logic [XLEN-1:0]               wd0,
    input  logic                          we1,
    input  logic [$clog2(NREG)-1:0]       wa1,
    input  logic [XLEN-1:0]               wd1,
    input  logic                          iss_v,
    input  logic [$clog2(NREG)-1:0]       iss_a,
    output logic [NREG-1:0]               busy_vec
);

    localparam int AW       = $clog2(NREG);
    localparam bit C_BYPASS = (BYPASS != 0);

    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_wr0;
    logic            w_wr1;
    logic            w_iss;

    // Register 0 is hardwired: writes and issues to it are dropped here.
    assign w_wr0 = we0 && (wa0 != '0);
    assign w_wr1 = we1 && (wa1 != '0);
    assign w_iss = iss_v && (iss_a != '0);

    // Writeback clears first, then issue sets, so set wins on a collision.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0) w_busy_nxt[wa0] = 1'b0;
        if (w_wr1) w_busy_nxt[wa1] = 1'b0;
        if (w_iss) w_busy_nxt[iss_a] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Port 1 is written last so it wins when both ports target one address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            for (int n = 0; n < NREG; n++) begin
                r_mem[n] <= '0;
            end
        end else begin
            r_busy <= w_busy_nxt;
            if (w_wr0) r_mem[wa0] <= wd0;
            if (w_wr1) r_mem[wa1] <= wd1;
        end
    end

    assign busy_vec = r_busy;

    genvar i;
    generate
        for (i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0]   w_addr;
            logic            w_hit0;
            logic            w_hit1;
            logic [XLEN-1:0] w_data;

            assign w_addr = ra[i*AW +: AW];
            assign w_hit0 = C_BYPASS && w_wr0 && (wa0 == w_addr);
            assign w_hit1 = C_BYPASS && w_wr1 && (wa1 == w_addr);

            always_comb begin
                if (w_hit1)              w_data = wd1;
                else if (w_hit0)         w_data = wd0;
                else if (w_addr == '0)   w_data = '0;
                else                     w_data = r_mem[w_addr];
            end

            // A forwarded value is already available, so it reports not-busy.
            assign rd[i*XLEN +: XLEN] = w_data;
            assign rbusy[i]           = r_busy[w_addr] && !(w_hit0 || w_hit1);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench: bypass and non-bypass instances against
//               an array/bitmask reference model plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd_b, rd_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic                we0, we1, iss_v;
    logic [AW-1:0]       wa0, wa1, iss_a;
    logic [XLEN-1:0]     wd0, wd1;
    logic [NREG-1:0]     bv_b, bv_n;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [XLEN-1:0] m_mem [NREG];
    logic [NREG-1:0] m_busy;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_v(iss_v), .iss_a(iss_a), .busy_vec(bv_b)
    );

    regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss_v(iss_v), .iss_a(iss_a), .busy_vec(bv_n)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the register file is an array, the scoreboard a bitmask.
    always @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < NREG; n++) m_mem[n] = '0;
            m_busy = '0;
        end else begin
            if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_busy[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_busy[wa1] = 1'b0; end
            if (iss_v && iss_a != 0) m_busy[iss_a] = 1'b1;
        end
    end

    function automatic logic written(input logic [AW-1:0] a);
        return (a != 0) && ((we0 && wa0 == a) || (we1 && wa1 == a));
    endfunction

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NRD; p++) begin
                logic [AW-1:0] a;
                a = ra[p*AW +: AW];
                check("model_rd_byp",    rd_b[p*XLEN +: XLEN], exp_rd(a, 1'b1));
                check("model_rd_nobyp",  rd_n[p*XLEN +: XLEN], exp_rd(a, 1'b0));
                check("model_rbusy_byp", rbusy_b[p], m_busy[a] && !written(a));
                check("model_rbusy_nobyp", rbusy_n[p], m_busy[a]);
            end
            check("model_busy_vec_byp",   bv_b, m_busy);
            check("model_busy_vec_nobyp", bv_n, m_busy);
        end
    end

    task automatic idle();
        we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
        iss_v = 0; iss_a = 0; rst = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        ra  = '0;
        for (int n = 0; n < NREG; n++) m_mem[n] = '0;
        m_busy = '0;
        next_cycle();
        rst = 0;
        chk_en = 1'b1;

        // Post-reset: every address reads zero and nothing is busy.
        for (int a = 0; a < NREG; a++) begin
            ra = {AW'(NREG - 1 - a), AW'(a)};
            @(negedge clk);
            check("rst_rd_byp", rd_b, 64'h0);
            check("rst_rd_nobyp", rd_n, 64'h0);
            check("rst_rbusy", {rbusy_b, rbusy_n}, 64'h0);
            check("rst_busy_vec", bv_b, 64'h0);
            next_cycle();
        end

        // Same-cycle write/read of address 5.
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra = {AW'(0), AW'(5)};
        @(negedge clk);
        check("bypass_rd0", rd_b[31:0], 64'hDEADBEEF);
        check("nobypass_rd0", rd_n[31:0], 64'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check("after_wr_byp", rd_b[31:0], 64'hDEADBEEF);
        check("after_wr_nobyp", rd_n[31:0], 64'hDEADBEEF);
        next_cycle();

        // Dual write to address 7: port 1 wins.
        we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra = {AW'(7), AW'(7)};
        @(negedge clk);
        check("dual_bypass", rd_b, {32'h22, 32'h22});
        next_cycle();
        idle();
        @(negedge clk);
        check("dual_read_byp", rd_b[63:32], 64'h22);
        check("dual_read_nobyp", rd_n[63:32], 64'h22);
        next_cycle();

        // Issue to 3, two idle cycles, then load writeback.
        iss_v = 1; iss_a = 3; ra = {AW'(0), AW'(3)};
        next_cycle();
        idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("pending_busy3", bv_b[3], 64'h1);
            check("pending_rbusy", rbusy_b[0], 64'h1);
            next_cycle();
        end
        we1 = 1; wa1 = 3; wd1 = 32'h55;
        @(negedge clk);
        check("wb_busy3_still", bv_b[3], 64'h1);
        check("wb_rbusy_byp", rbusy_b[0], 64'h0);
        check("wb_rbusy_nobyp", rbusy_n[0], 64'h1);
        check("wb_fwd_data", rd_b[31:0], 64'h55);
        next_cycle();
        idle();
        @(negedge clk);
        check("wb_busy3_clear", bv_b[3], 64'h0);
        check("wb_data_nobyp", rd_n[31:0], 64'h55);
        next_cycle();

        // Same-cycle issue and writeback to 9: set wins, data written.
        iss_v = 1; iss_a = 9; we0 = 1; wa0 = 9; wd0 = 32'h1; ra = {AW'(0), AW'(9)};
        next_cycle();
        idle();
        @(negedge clk);
        check("iss_wb_busy9", bv_b[9], 64'h1);
        check("iss_wb_data9", rd_n[31:0], 64'h1);
        check("iss_wb_rbusy9", rbusy_b[0], 64'h1);
        next_cycle();
        iss_v = 1; iss_a = 9;
        next_cycle();
        idle();

        // Two distinct addresses written in one cycle.
        we0 = 1; wa0 = 10; wd0 = 32'hAA; we1 = 1; wa1 = 11; wd1 = 32'hBB; ra = {AW'(11), AW'(10)};
        next_cycle();
        idle();
        @(negedge clk);
        check("two_addr_nobyp", rd_n, {32'hBB, 32'hAA});
        check("reissue_busy9", bv_b[9], 64'h1);
        next_cycle();

        // Register 0 is untouchable.
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF; we1 = 1; wa1 = 0; wd1 = 32'h1234;
        iss_v = 1; iss_a = 0; ra = '0;
        @(negedge clk);
        check("r0_bypass", rd_b, 64'h0);
        next_cycle();
        idle();
        @(negedge clk);
        check("r0_busy", bv_b[0], 64'h0);
        check("r0_rd", rd_n, 64'h0);
        next_cycle();

        // Build busy_vec 0x208, then reset with writes/issue that must be ignored.
        iss_v = 1; iss_a = 3;
        next_cycle();
        idle();
        @(negedge clk);
        check("pre_rst_busy_vec", bv_b, 64'h208);
        next_cycle();
        rst = 1; we0 = 1; wa0 = 4; wd0 = 32'h77; iss_v = 1; iss_a = 4;
        next_cycle();
        idle();
        ra = {AW'(9), AW'(4)};
        we1 = 1; wa1 = 3; wd1 = 32'h66;
        @(negedge clk);
        check("post_rst_busy_vec", bv_n, 64'h0);
        check("post_rst_rd_nobyp", rd_n, 64'h0);
        next_cycle();
        idle();
        ra = {AW'(3), AW'(4)};
        @(negedge clk);
        check("post_rst_wb_data", rd_n[63:32], 64'h66);
        check("post_rst_wb_busy", bv_b, 64'h0);
        next_cycle();

        // Dense traffic on a few addresses, checked by the model every cycle.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 49) == 0);
            we0   = 1'($urandom_range(0, 1));
            wa0   = AW'($urandom_range(0, 7));
            wd0   = $urandom;
            we1   = 1'($urandom_range(0, 1));
            wa1   = AW'($urandom_range(0, 7));
            wd1   = $urandom;
            iss_v = 1'($urandom_range(0, 1));
            iss_a = AW'($urandom_range(0, 7));
            ra    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            next_cycle();
        end
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
